// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port framebuffer RAM between fixed
// display-fetch slots and a req/ack pixel writer, and registers rgb.
// Ports: clk, reset (async, active-high); sync inputs p_tick, video_on,
// pixel_x, pixel_y; writer wr_req/wr_addr/wr_data -> wr_ack;
// RAM mem_addr/mem_we/mem_wdata -> mem_rdata; registered pixel rgb.
module vram_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int AW   = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    rgb
);

    localparam int            FB_WORDS = FB_W * FB_H;
    localparam logic [AW-1:0] FB_LIMIT = AW'(FB_WORDS);

    logic          act_fetch;
    logic          pre_fetch;
    logic          disp_slot;
    logic [9:0]    next_y;
    logic [8:0]    src_row;
    logic [8:0]    src_col;
    logic [AW-1:0] row_base;
    logic [AW-1:0] fetch_addr;
    logic          fetch_d;
    logic [7:0]    pix_buf;

    assign next_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;

    // Odd-pixel slots fetch the next source column, so the word is
    // in pix_buf before the pair of screen pixels that shows it.
    assign act_fetch = p_tick && pixel_x[0]
                    && (pixel_x <= 10'd637) && (pixel_y < 10'd480);

    // End of line: prefetch column 0 of the coming line.
    assign pre_fetch = p_tick && (pixel_x == 10'd799)
                    && (next_y < 10'd480);

    assign disp_slot = act_fetch || pre_fetch;

    assign src_row = act_fetch ? pixel_y[9:1] : next_y[9:1];
    assign src_col = act_fetch ? pixel_x[9:1] + 9'd1 : 9'd0;

    // row*320 as (row<<8)+(row<<6): no multiplier.
    assign row_base   = (AW'(src_row) << 8) + (AW'(src_row) << 6);
    assign fetch_addr = row_base + AW'(src_col);

    assign mem_wdata = wr_data;

    // Fixed priority: display slot, then writer, else idle.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        wr_ack   = 1'b0;
        if (disp_slot) begin
            mem_addr = fetch_addr;
        end else if (wr_req) begin
            mem_addr = wr_addr;
            wr_ack   = 1'b1;
            // Out-of-range writes are consumed but never reach RAM.
            mem_we   = (wr_addr < FB_LIMIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_d <= 1'b0;
            pix_buf <= 8'h00;
            rgb     <= 8'h00;
        end else begin
            fetch_d <= disp_slot;
            if (fetch_d) begin
                pix_buf <= mem_rdata;
            end
            if (p_tick) begin
                rgb <= video_on ? pix_buf : 8'h00;
            end
        end
    end

endmodule
